// File: rtl/scan_chain_ctrl.sv
// Serial configuration loader for a chain of inverting (D -> QN) scan flops.
// Shifts a word in with parity pre-compensation and recovers the displaced word from SO.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int SETTLE    = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 rb_valid,
    output logic [CHAIN_LEN-1:0] rb_data,
    output logic                 busy
);

    localparam int CW = $clog2(CHAIN_LEN) + 1;
    localparam logic [CW-1:0] LAST_IDX    = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    // Parity of CHAIN_LEN-1; the shift count t = CHAIN_LEN-1-j has parity N1_ODD ^ j[0].
    localparam logic N1_ODD = 1'((CHAIN_LEN - 1) % 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic [CHAIN_LEN-1:0] rb_data_q;
    logic                 rb_valid_q;
    logic                 busy_q;
    logic                 so_corr;

    // One register both feeds SI from its top and collects corrected SO samples at its bottom.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        cfg_ready = 1'b0;
        SE        = 1'b0;
        SI        = 1'b0;
        so_corr   = SO ^ N1_ODD ^ cnt_q[0];
        case (state_q)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_d = S_SHIFT;
                    cnt_d   = LAST_IDX;
                    sr_d    = cfg_data;
                end
            end
            S_SHIFT: begin
                SE   = 1'b1;
                SI   = sr_q[CHAIN_LEN-1] ^ ~cnt_q[0];
                sr_d = {sr_q[CHAIN_LEN-2:0], so_corr};
                if (cnt_q == '0) begin
                    if (SETTLE > 0) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_LAST;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // No chain edge may happen while reset is asserted.
        if (RST) begin
            SE = 1'b0;
            SI = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rb_valid_q <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            if (state_d == S_DONE) begin
                rb_data_q <= sr_d;
            end
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two configurations (4/2 and 8/0) driving behavioural inverting chains,
// a cycle-schedule reference model with a per-cycle compare, and hand-computed directed checks.
module tb_scan_chain_ctrl;

    localparam int NA = 4;
    localparam int SA = 2;
    localparam int NB = 8;
    localparam int SB = 0;

    logic       clk;
    logic [1:0] rst;
    logic [1:0] vld;
    logic [1:0] ready;
    logic [1:0] se;
    logic [1:0] si;
    logic [1:0] so;
    logic [1:0] rbv;
    logic [1:0] busy;
    logic [7:0] cd0;
    logic [7:0] cd1;
    logic [3:0] rbd0;
    logic [7:0] rbd1;

    int checks;
    int failures;

    scan_chain_ctrl #(.CHAIN_LEN(NA), .SETTLE(SA)) dut_a (
        .CLK(clk), .RST(rst[0]), .cfg_valid(vld[0]), .cfg_ready(ready[0]),
        .cfg_data(cd0[3:0]), .SE(se[0]), .SI(si[0]), .SO(so[0]),
        .rb_valid(rbv[0]), .rb_data(rbd0), .busy(busy[0])
    );

    scan_chain_ctrl #(.CHAIN_LEN(NB), .SETTLE(SB)) dut_b (
        .CLK(clk), .RST(rst[1]), .cfg_valid(vld[1]), .cfg_ready(ready[1]),
        .cfg_data(cd1), .SE(se[1]), .SI(si[1]), .SO(so[1]),
        .rb_valid(rbv[1]), .rb_data(rbd1), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical chain: bit k-1 is QN of stage k; every enabled edge inverts what it captures.
    logic [7:0] ch [2];
    initial begin
        ch[0] = 8'h00;
        ch[1] = 8'h00;
    end
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (se[d]) ch[d] <= ~{ch[d][6:0], si[d]};
        end
    end
    assign so = {ch[1][7], ch[0][3]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_rbd(input int d);
        return (d == 0) ? {4'h0, rbd0} : rbd1;
    endfunction

    // Reference model: a load accepted in cycle c0 occupies cycles c0+1 .. c0+N+S+1.
    int         cyc;
    bit         started    [2];
    bit         act        [2];
    int         c0         [2];
    logic [7:0] wrd        [2];
    logic [7:0] exp_rb     [2];
    bit         rb_known   [2];
    bit         chain_known[2];
    logic [7:0] hold       [2];
    bit         hold_known [2];

    initial begin
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            started[d] = 0; act[d] = 0; c0[d] = 0; wrd[d] = 0; exp_rb[d] = 0;
            rb_known[d] = 0; chain_known[d] = 0; hold[d] = 0; hold_known[d] = 0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int n, s;
            n = (d == 0) ? NA : NB;
            s = (d == 0) ? SA : SB;
            if (rst[d]) begin
                started[d] = 1; act[d] = 0; hold[d] = 8'h00; hold_known[d] = 1;
                chain_known[d] = 0;
            end else if (started[d]) begin
                if (act[d] && cyc == c0[d] + n + s + 1) begin
                    act[d] = 0;
                    chain_known[d] = 1;
                end else if (!act[d] && vld[d]) begin
                    act[d]      = 1;
                    c0[d]       = cyc;
                    wrd[d]      = (d == 0) ? cd0 : cd1;
                    exp_rb[d]   = ch[d] & ((d == 0) ? 8'h0F : 8'hFF);
                    rb_known[d] = chain_known[d];
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (started[d]) begin
                int n, s, k, j;
                logic e_se, e_si, e_rbv;
                n = (d == 0) ? NA : NB;
                s = (d == 0) ? SA : SB;
                k = cyc - c0[d];
                e_se = act[d] && (k <= n) && !rst[d];
                e_si = 1'b0;
                if (e_se) begin
                    j    = n - k;
                    e_si = wrd[d][j] ^ ((j % 2) == 0);
                end
                e_rbv = act[d] && (k == n + s + 1);
                if (e_rbv) begin
                    hold[d]       = exp_rb[d];
                    hold_known[d] = rb_known[d];
                end
                chk($sformatf("d%0d_ctl_x", d),
                    {31'd0, $isunknown({se[d], si[d], ready[d], rbv[d], busy[d]})}, 0);
                chk($sformatf("d%0d_se", d), {31'd0, se[d]}, {31'd0, e_se});
                chk($sformatf("d%0d_ready", d), {31'd0, ready[d]}, {31'd0, !act[d]});
                chk($sformatf("d%0d_busy", d), {31'd0, busy[d]}, {31'd0, act[d]});
                chk($sformatf("d%0d_rbv", d), {31'd0, rbv[d]}, {31'd0, e_rbv});
                if (e_se || rst[d]) chk($sformatf("d%0d_si", d), {31'd0, si[d]}, {31'd0, e_si});
                if (hold_known[d]) chk($sformatf("d%0d_rbdata", d), {24'd0, get_rbd(d)}, {24'd0, hold[d]});
            end
        end
    end

    // Handshake one word, then observe cycles 1.. until rb_valid (relative to the handshake cycle).
    task automatic do_load(input int d, input logic [7:0] w,
                           output logic [7:0] si_seq, output int se_cnt, output int se_first,
                           output int se_last, output int rb_cyc, output logic [7:0] rb_seen);
        int n;
        n = 0;
        while (!ready[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("d%0d_ready_wait", d), {31'd0, ready[d]}, 1);
        vld[d] = 1'b1;
        if (d == 0) cd0 = w; else cd1 = w;
        @(posedge clk); #1;
        vld[d] = 1'b0;
        si_seq = 0; se_cnt = 0; se_first = 0; se_last = 0; rb_cyc = 0; rb_seen = 0;
        for (int k = 1; k <= 40 && rb_cyc == 0; k++) begin
            @(negedge clk);
            if (se[d]) begin
                si_seq = {si_seq[6:0], si[d]};
                se_cnt++;
                if (se_first == 0) se_first = k;
                se_last = k;
            end
            if (rbv[d]) begin
                rb_cyc  = k;
                rb_seen = get_rbd(d);
            end
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] sq, rbs;
    int         sc, sf, sl, rc;
    int         acc, lowcnt, rbcount;
    int         acc_cyc [3];
    logic [3:0] words   [3];

    initial begin
        checks = 0; failures = 0;
        rst = 2'b11; vld = 2'b00; cd0 = 8'h00; cd1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;

        // 4-stage chain, SETTLE=2
        do_load(0, 8'h0A, sq, sc, sf, sl, rc, rbs);
        chk("a_1010_si", {28'd0, sq[3:0]}, 32'hF);
        chk("a_1010_se_cnt", sc, 4);
        chk("a_1010_se_first", sf, 1);
        chk("a_1010_se_last", sl, 4);
        chk("a_1010_rb_cycle", rc, 7);
        chk("a_1010_chain", {28'd0, ch[0][3:0]}, 32'hA);

        do_load(0, 8'h00, sq, sc, sf, sl, rc, rbs);
        chk("a_0000_si", {28'd0, sq[3:0]}, 32'h5);
        chk("a_0000_rb", {28'd0, rbs[3:0]}, 32'hA);
        chk("a_0000_chain", {28'd0, ch[0][3:0]}, 32'h0);

        do_load(0, 8'h06, sq, sc, sf, sl, rc, rbs);
        chk("a_0110_rb", {28'd0, rbs[3:0]}, 32'h0);
        do_load(0, 8'h0F, sq, sc, sf, sl, rc, rbs);
        chk("a_1111_rb", {28'd0, rbs[3:0]}, 32'h6);

        // cfg_valid held for 24 cycles: only three words fit
        words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'h9;
        acc = 0; lowcnt = 0;
        vld[0] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            cd0 = (ready[0] && acc < 3) ? {4'h0, words[acc]} : 8'h0F;
            @(negedge clk);
            if (ready[0]) begin
                if (acc < 3) acc_cyc[acc] = c;
                acc++;
            end else begin
                lowcnt++;
            end
            @(posedge clk); #1;
        end
        vld[0] = 1'b0;
        chk("b2b_accepts", acc, 3);
        chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 8);
        chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 8);
        chk("b2b_ready_low", lowcnt, 21);
        do_load(0, 8'h00, sq, sc, sf, sl, rc, rbs);
        chk("b2b_last_rb", {28'd0, rbs[3:0]}, 32'h9);

        // Abort in the third SHIFT cycle
        vld[0] = 1'b1; cd0 = 8'h0C;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_se", {31'd0, se[0]}, 0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("abort_ready", {31'd0, ready[0]}, 1);
        chk("abort_rbv", {31'd0, rbv[0]}, 0);
        chk("abort_busy", {31'd0, busy[0]}, 0);
        rbcount = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rbv[0]) rbcount++;
            @(posedge clk); #1;
        end
        chk("abort_no_rbv", rbcount, 0);

        // 8-stage chain, SETTLE=0
        do_load(1, 8'hA5, sq, sc, sf, sl, rc, rbs);
        chk("b_a5_si", {24'd0, sq}, 32'hF0);
        chk("b_a5_se_cnt", sc, 8);
        chk("b_a5_se_first", sf, 1);
        chk("b_a5_se_last", sl, 8);
        chk("b_a5_rb_cycle", rc, 9);
        chk("b_a5_chain", {24'd0, ch[1]}, 32'hA5);
        do_load(1, 8'h3C, sq, sc, sf, sl, rc, rbs);
        chk("b_3c_rb", {24'd0, rbs}, 32'hA5);
        chk("b_3c_chain", {24'd0, ch[1]}, 32'h3C);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
